// File: rtl/gpio_seq_core.sv
// gpio_seq_core: walks a single lit bit across NUM_CH outputs at a prescaled rate.
// Optional feature macro GPIO_SEQ_PINGPONG_EN builds ping-pong mode; without it mode 10 runs as up.
module gpio_seq_core #(
    parameter int NUM_CH         = 34,
    parameter int PRESC_W        = 14,
    parameter int TICKS_PER_UNIT = 10000,
    localparam int POS_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic [1:0]         mode_i,
    input  logic               oneshot_i,
    output logic [NUM_CH-1:0]  seq_o,
    output logic [POS_W-1:0]   pos_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int UNIT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;

    localparam logic [UNIT_W-1:0]  UNIT_MAX = UNIT_W'(TICKS_PER_UNIT - 1);
    localparam logic [POS_W-1:0]   LAST_POS = POS_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0]   POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]   POS_ZERO = '0;
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [NUM_CH-1:0]  BIT0     = NUM_CH'(1);

    logic [1:0]         state;
    logic [1:0]         mode_q;
    logic [PRESC_W-1:0] presc_q;
    logic               oneshot_q;

    logic [UNIT_W-1:0]  unit_cnt;
    logic [PRESC_W-1:0] step_cnt;
    logic               unit_wrap;
    logic               step_tick;
    logic               start_run;

    logic               lit;
    logic [POS_W-1:0]   pos;

    logic               up_lit;
    logic [POS_W-1:0]   up_pos;
    logic               up_end;
    logic               down_lit;
    logic [POS_W-1:0]   down_pos;
    logic               down_end;

`ifdef GPIO_SEQ_PINGPONG_EN
    logic               dir;
    logic               pp_lit;
    logic [POS_W-1:0]   pp_pos;
    logic               pp_dir;
    logic               pp_end;
    logic               nxt_dir;
`endif

    logic               nxt_lit;
    logic [POS_W-1:0]   nxt_pos;
    logic               pass_end;

    // A step fires only when both counters sit at their maximum; a zero prescaler stalls.
    assign unit_wrap = (unit_cnt == UNIT_MAX);
    assign step_tick = (state == ST_RUN) && (presc_q != '0) && unit_wrap &&
                       (step_cnt == presc_q - PRESC_ONE);
    assign start_run = en_i && (prescaler_i != '0);

    always_comb begin
        up_lit = 1'b1;
        up_pos = POS_ZERO;
        up_end = 1'b0;
        if (lit) begin
            if (pos == LAST_POS) begin
                up_lit = 1'b0;
                up_end = 1'b1;
            end else begin
                up_pos = pos + POS_ONE;
            end
        end
    end

    always_comb begin
        down_lit = 1'b1;
        down_pos = LAST_POS;
        down_end = 1'b0;
        if (lit) begin
            if (pos == POS_ZERO) begin
                down_lit = 1'b0;
                down_pos = POS_ZERO;
                down_end = 1'b1;
            end else begin
                down_pos = pos - POS_ONE;
            end
        end
    end

`ifdef GPIO_SEQ_PINGPONG_EN
    // Rising leg lights bit N-1 once and turns; falling leg clears after bit 0.
    always_comb begin
        pp_lit = 1'b1;
        pp_pos = POS_ZERO;
        pp_dir = 1'b0;
        pp_end = 1'b0;
        if (lit) begin
            if (!dir) begin
                if (pos == LAST_POS) begin
                    pp_dir = 1'b1;
                    pp_pos = pos - POS_ONE;
                end else begin
                    pp_pos = pos + POS_ONE;
                end
            end else begin
                pp_dir = 1'b1;
                if (pos == POS_ZERO) begin
                    pp_lit = 1'b0;
                    pp_dir = 1'b0;
                    pp_end = 1'b1;
                end else begin
                    pp_pos = pos - POS_ONE;
                end
            end
        end
    end
`endif

    always_comb begin
        nxt_lit  = lit;
        nxt_pos  = pos;
        pass_end = 1'b0;
`ifdef GPIO_SEQ_PINGPONG_EN
        nxt_dir  = dir;
`endif
        case (mode_q)
`ifdef GPIO_SEQ_PINGPONG_EN
            MODE_UP: begin
                nxt_lit  = up_lit;
                nxt_pos  = up_pos;
                pass_end = up_end;
            end
            MODE_PP: begin
                nxt_lit  = pp_lit;
                nxt_pos  = pp_pos;
                nxt_dir  = pp_dir;
                pass_end = pp_end;
            end
`else
            MODE_UP, MODE_PP: begin
                nxt_lit  = up_lit;
                nxt_pos  = up_pos;
                pass_end = up_end;
            end
`endif
            MODE_DOWN: begin
                nxt_lit  = down_lit;
                nxt_pos  = down_pos;
                pass_end = down_end;
            end
            default: begin
            end
        endcase
    end

    // A one-shot pass stays in RUN for the done cycle, then parks in STOP.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            mode_q    <= '0;
            presc_q   <= '0;
            oneshot_q <= 1'b0;
            unit_cnt  <= '0;
            step_cnt  <= '0;
            lit       <= 1'b0;
            pos       <= '0;
            done_o    <= 1'b0;
`ifdef GPIO_SEQ_PINGPONG_EN
            dir       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    unit_cnt <= '0;
                    step_cnt <= '0;
                    lit      <= 1'b0;
                    pos      <= '0;
                    done_o   <= 1'b0;
`ifdef GPIO_SEQ_PINGPONG_EN
                    dir      <= 1'b0;
`endif
                    if (start_run) begin
                        state     <= ST_RUN;
                        mode_q    <= mode_i;
                        presc_q   <= prescaler_i;
                        oneshot_q <= oneshot_i;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state    <= ST_IDLE;
                        unit_cnt <= '0;
                        step_cnt <= '0;
                        lit      <= 1'b0;
                        pos      <= '0;
                        done_o   <= 1'b0;
`ifdef GPIO_SEQ_PINGPONG_EN
                        dir      <= 1'b0;
`endif
                    end else if (done_o && oneshot_q) begin
                        state    <= ST_STOP;
                        unit_cnt <= '0;
                        step_cnt <= '0;
                        done_o   <= 1'b0;
                    end else begin
                        done_o <= 1'b0;
                        if (step_tick) begin
                            unit_cnt <= '0;
                            step_cnt <= '0;
                        end else if (unit_wrap) begin
                            unit_cnt <= '0;
                            step_cnt <= step_cnt + PRESC_ONE;
                        end else begin
                            unit_cnt <= unit_cnt + UNIT_W'(1);
                        end
                        if (step_tick) begin
                            lit <= nxt_lit;
                            pos <= nxt_pos;
`ifdef GPIO_SEQ_PINGPONG_EN
                            dir <= nxt_dir;
`endif
                            if (pass_end) begin
                                done_o <= 1'b1;
                                if (!oneshot_q) begin
                                    presc_q <= prescaler_i;
                                end
                            end
                        end
                    end
                end
                ST_STOP: begin
                    unit_cnt <= '0;
                    step_cnt <= '0;
                    lit      <= 1'b0;
                    pos      <= '0;
                    done_o   <= 1'b0;
                    if (!en_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    unit_cnt <= '0;
                    step_cnt <= '0;
                    lit      <= 1'b0;
                    pos      <= '0;
                    done_o   <= 1'b0;
                end
            endcase
        end
    end

    assign seq_o  = lit ? (BIT0 << pos) : '0;
    assign pos_o  = pos;
    assign busy_o = (state == ST_RUN);

endmodule

// File: tb/tb_gpio_seq_core.sv
// tb_gpio_seq_core: directed checks of gpio_seq_core with NUM_CH=4, TICKS_PER_UNIT=10, PRESC_W=4.
// Expected ping-pong tables depend on GPIO_SEQ_PINGPONG_EN being defined for the build.
module tb_gpio_seq_core;

    localparam int NUM_CH  = 4;
    localparam int PRESC_W = 4;
    localparam int TPU     = 10;
    localparam int POS_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [PRESC_W-1:0] presc;
    logic [1:0]         mode;
    logic               oneshot;
    logic [NUM_CH-1:0]  seq;
    logic [POS_W-1:0]   pos;
    logic               busy;
    logic               done;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef GPIO_SEQ_PINGPONG_EN
    logic [3:0] t4_seq  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
    logic [1:0] t4_pos  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    logic       t4_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic [3:0] t4_seq  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4};
    logic [1:0] t4_pos  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    logic       t4_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    logic [3:0] t2_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h0};
    logic [1:0] t2_pos [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clk = ~clk;

    gpio_seq_core #(
        .NUM_CH(NUM_CH),
        .PRESC_W(PRESC_W),
        .TICKS_PER_UNIT(TPU)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .en_i(en),
        .prescaler_i(presc),
        .mode_i(mode),
        .oneshot_i(oneshot),
        .seq_o(seq),
        .pos_o(pos),
        .busy_o(busy),
        .done_o(done)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [PRESC_W-1:0] p,
                                 input logic [1:0] m, input logic o);
        en      = e;
        presc   = p;
        mode    = m;
        oneshot = o;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 4'd0, 2'b00, 1'b0);
        tick(2);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 2'b00, 1'b0);

        // T1 reset
        tick(2);
        checkOutput("T1 seq", 32'(seq), 32'h0);
        checkOutput("T1 pos", 32'(pos), 32'h0);
        checkOutput("T1 busy", 32'(busy), 32'h0);
        checkOutput("T1 done", 32'(done), 32'h0);
        rst = 1'b0;
        tick(1);

        // T2 up, prescaler 2
        applyStimulus(1'b1, 4'd2, 2'b00, 1'b0);
        tick(1);
        checkOutput("T2 busy at entry", 32'(busy), 32'h1);
        checkOutput("T2 seq at entry", 32'(seq), 32'h0);
        tick(19);
        checkOutput("T2 seq at +19", 32'(seq), 32'h0);
        tick(1);
        checkOutput("T2 seq at +20", 32'(seq), 32'h1);
        checkOutput("T2 pos at +20", 32'(pos), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(19);
            checkOutput($sformatf("T2 done before step%0d", i + 2), 32'(done), 32'h0);
            tick(1);
            checkOutput($sformatf("T2 seq step%0d", i + 2), 32'(seq), 32'(t2_seq[i]));
            checkOutput($sformatf("T2 pos step%0d", i + 2), 32'(pos), 32'(t2_pos[i]));
        end
        checkOutput("T2 done at +100", 32'(done), 32'h1);
        tick(1);
        checkOutput("T2 done at +101", 32'(done), 32'h0);
        tick(19);
        checkOutput("T2 seq at +120", 32'(seq), 32'h1);
        goIdle();

        // T5 abort mid-pass, then restart
        applyStimulus(1'b1, 4'd2, 2'b00, 1'b0);
        tick(21);
        checkOutput("T5 seq at +20", 32'(seq), 32'h1);
        tick(15);
        en = 1'b0;
        tick(1);
        checkOutput("T5 seq after abort", 32'(seq), 32'h0);
        checkOutput("T5 pos after abort", 32'(pos), 32'h0);
        checkOutput("T5 busy after abort", 32'(busy), 32'h0);
        seen = done;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | done;
        end
        checkOutput("T5 no done after abort", 32'(seen), 32'h0);
        en = 1'b1;
        tick(1);
        tick(19);
        checkOutput("T5 seq at +19 restart", 32'(seq), 32'h0);
        tick(1);
        checkOutput("T5 seq at +20 restart", 32'(seq), 32'h1);
        goIdle();

        // T3 down one-shot; later input changes must be ignored
        applyStimulus(1'b1, 4'd1, 2'b01, 1'b1);
        tick(1);
        tick(10);
        checkOutput("T3 seq step1", 32'(seq), 32'h8);
        checkOutput("T3 pos step1", 32'(pos), 32'h3);
        mode    = 2'b00;
        oneshot = 1'b0;
        tick(10);
        checkOutput("T3 seq step2", 32'(seq), 32'h4);
        tick(10);
        checkOutput("T3 seq step3", 32'(seq), 32'h2);
        tick(10);
        checkOutput("T3 seq step4", 32'(seq), 32'h1);
        checkOutput("T3 pos step4", 32'(pos), 32'h0);
        tick(10);
        checkOutput("T3 seq step5", 32'(seq), 32'h0);
        checkOutput("T3 done step5", 32'(done), 32'h1);
        tick(1);
        checkOutput("T3 done after pulse", 32'(done), 32'h0);
        checkOutput("T3 busy in stop", 32'(busy), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            seen = seen | done | busy | (seq != 4'h0);
        end
        checkOutput("T3 quiet in stop", 32'(seen), 32'h0);
        goIdle();

        // T4 ping-pong (up when the feature is not built)
        applyStimulus(1'b1, 4'd1, 2'b10, 1'b0);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            tick(10);
            checkOutput($sformatf("T4 seq step%0d", i + 1), 32'(seq), 32'(t4_seq[i]));
            checkOutput($sformatf("T4 pos step%0d", i + 1), 32'(pos), 32'(t4_pos[i]));
            checkOutput($sformatf("T4 done step%0d", i + 1), 32'(done), 32'(t4_done[i]));
        end
        goIdle();

        // T6 prescaler latch: change 2->3 mid-pass
        applyStimulus(1'b1, 4'd2, 2'b00, 1'b0);
        tick(1);
        tick(30);
        checkOutput("T6 seq at +30", 32'(seq), 32'h1);
        presc = 4'd3;
        tick(10);
        checkOutput("T6 seq at +40", 32'(seq), 32'h2);
        tick(20);
        checkOutput("T6 seq at +60", 32'(seq), 32'h4);
        tick(20);
        checkOutput("T6 seq at +80", 32'(seq), 32'h8);
        tick(20);
        checkOutput("T6 seq at +100", 32'(seq), 32'h0);
        checkOutput("T6 done at +100", 32'(done), 32'h1);
        tick(29);
        checkOutput("T6 seq at +129", 32'(seq), 32'h0);
        tick(1);
        checkOutput("T6 seq at +130", 32'(seq), 32'h1);
        tick(30);
        checkOutput("T6 seq at +160", 32'(seq), 32'h2);

        // Reset mid-pass wins over en
        rst = 1'b1;
        tick(1);
        checkOutput("RST seq", 32'(seq), 32'h0);
        checkOutput("RST busy", 32'(busy), 32'h0);
        checkOutput("RST done", 32'(done), 32'h0);
        rst = 1'b0;
        goIdle();

        // Zero prescaler never starts
        applyStimulus(1'b1, 4'd0, 2'b00, 1'b0);
        tick(5);
        checkOutput("P0 busy", 32'(busy), 32'h0);
        goIdle();

        // Hold mode keeps the output frozen and raises no done
        applyStimulus(1'b1, 4'd1, 2'b11, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            seen = seen | done | (seq != 4'h0);
        end
        checkOutput("HOLD quiet", 32'(seen), 32'h0);
        checkOutput("HOLD busy", 32'(busy), 32'h1);
        goIdle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
